prim_memctl: RTL and testbench
==============================

Name: prim_memctl

Overview:
- Bus slave that sits directly downstream of the Prim CPU core and serves every fetch, load and store it issues.
- Decodes the CPU's 16-bit byte address into two targets: a word-wide single-port synchronous RAM, or a 256-byte I/O page.
- Inserts the configured wait states and performs read-modify-write for byte stores, because the RAM has no byte enables.
- Returns a one-cycle acknowledge to the CPU when each access completes.

Parameters:
- RAM_AW, 14, RAM word-address width (2^RAM_AW 16-bit words).
- WAIT_STATES, 0, extra cycles added to every RAM access (0..15).
- IO_PAGE, 8'hFF, value of i_addr[15:8] that selects the I/O window.
- IO_TIMEOUT, 15, number of cycles after the I/O strobe before the access is aborted (1..255).

Ports:
- i_clk, input, 1, system clock.
- i_reset, input, 1, synchronous active-high reset.
- i_addr, input, 16, CPU byte address.
- i_dat, input, 16, CPU write data.
- o_dat, output, 16, read data to the CPU; valid only while o_ack=1.
- i_bs, input, 2, byte select: 00 = no access, 01 = byte, 11 = word, 10 = treated as 11.
- i_we, input, 1, write when 1, read when 0.
- o_ack, output, 1, one-cycle access-complete pulse.
- o_ram_addr, output, RAM_AW, RAM word address.
- o_ram_dat, output, 16, RAM write data.
- i_ram_dat, input, 16, RAM read data, valid one cycle after o_ram_addr is presented.
- o_ram_we, output, 1, RAM write enable.
- o_io_addr, output, 8, I/O register address (i_addr[7:0]).
- o_io_dat, output, 16, I/O write data.
- i_io_dat, input, 16, I/O read data, valid while i_io_ack=1.
- o_io_re, output, 1, one-cycle I/O read strobe.
- o_io_we, output, 1, one-cycle I/O write strobe.
- i_io_ack, input, 1, I/O access complete.
- o_buserr, output, 1, one-cycle pulse when an I/O access times out; coincides with o_ack.

Behaviour:
- Clocking and reset: one clock, i_clk. i_reset is synchronous and active-high. It forces state IDLE and drives every output to 0, all counters to 0, and all latches to 0. Reset in the middle of an access abandons it: no ack is issued, and o_ram_we/o_io_* are low from the next edge onward.
- Request capture: a request is valid when i_bs != 00 in IDLE. At that edge the controller latches addr, dat, bs and we. The CPU holds its request until ack. The cycle after o_ack the controller is back in IDLE and treats whatever is presented as a new request, so there is no back-to-back ack for the same access.
- Address decode:
  - I/O when i_addr[15:8] == IO_PAGE; RAM otherwise.
  - RAM word address = addr[RAM_AW:1]; higher bits are ignored and wrap.
  - Word accesses ignore addr[0].
- Byte lanes (little-endian): addr[0]=0 selects bits 7:0; addr[0]=1 selects bits 15:8.
  - Byte read returns {8'h00, lane}.
  - Byte write places i_dat[7:0] into the selected lane and preserves the other lane.
- State machine: IDLE, RAM_RD, RAM_WAIT, RMW_WR, IO_WAIT, DONE.
  - IDLE -> RAM_RD for a RAM read or a RAM byte write.
  - IDLE -> RMW_WR for a RAM word write, writing directly.
  - IDLE -> IO_WAIT for I/O, with the strobe issued on entry.
  - RAM_RD presents o_ram_addr, then counts WAIT_STATES cycles in RAM_WAIT. The data is captured one cycle after the last wait cycle.
  - A byte write then goes to RMW_WR with the merged word. A read goes to DONE.
  - RMW_WR asserts o_ram_we for exactly one cycle, after WAIT_STATES wait cycles, then goes to DONE.
  - DONE asserts o_ack for one cycle with o_dat valid, then goes to IDLE.
- Latency with WAIT_STATES=0, counted as cycles from the cycle the request is first seen in IDLE (cycle 0) to o_ack:
  - Word write: ack in cycle 2.
  - Word or byte read: ack in cycle 3.
  - Byte write: ack in cycle 4.
  - Each wait state adds 1 cycle per RAM phase; a byte write has 2 phases.
- I/O access:
  - o_io_re or o_io_we is high for exactly the first IO_WAIT cycle.
  - o_io_dat = latched dat. i_bs is ignored for the strobe; byte reads zero-extend i_io_dat[7:0].
  - i_io_ack may arrive in the strobe cycle or later. Data is captured in that cycle, and o_ack follows the next cycle.
  - Timeout counter starts at the strobe. If i_io_ack has not arrived after IO_TIMEOUT cycles, the controller asserts o_ack with o_dat=0 and o_buserr=1 in the same cycle.
  - A late i_io_ack after a timeout is ignored.
- Output hygiene: o_ram_we, o_io_re and o_io_we are never high at the same time as o_ack.

Test Plan:
- Reset, then hold i_bs=00 for 10 cycles -> o_ack, o_ram_we, o_io_re, o_io_we and o_buserr stay 0.
- Word write addr 16'h0010 data 16'hBEEF, then word read 16'h0010, with WAIT_STATES=0 -> o_ram_addr=8, o_ram_we pulses once, write ack in cycle 2, read ack in cycle 3 with o_dat=16'hBEEF.
- Byte write 8'h5A to 16'h0011 over stored 16'hBEEF -> RAM holds 16'h5AEF, ack in cycle 4; byte read 16'h0011 -> 16'h005A; byte read 16'h0010 -> 16'h00EF.
- With WAIT_STATES=2: word read -> ack in cycle 5; byte write -> ack in cycle 8.
- I/O read at 16'hFF04 with i_io_ack 3 cycles after the strobe, i_io_dat=16'h1234 -> o_io_addr=8'h04, o_io_re one cycle, o_ack with o_dat=16'h1234, o_buserr=0. I/O write with no ack -> after IO_TIMEOUT cycles, o_ack and o_buserr pulse together with o_dat=0.
- Assert i_reset during RAM_WAIT of a byte write -> no o_ram_we and no o_ack; RAM is unchanged; the next request after reset completes normally.

Source files
------------

// File: rtl/prim_memctl.sv
// prim_memctl: Prim CPU bus slave serving RAM (wait states, byte read-modify-write) and an I/O page
module prim_memctl #(
  parameter int RAM_AW = 14,
  parameter int WAIT_STATES = 0,
  parameter logic [7:0] IO_PAGE = 8'hFF,
  parameter int IO_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [15:0]       i_addr,
  input  logic [15:0]       i_dat,
  output logic [15:0]       o_dat,
  input  logic [1:0]        i_bs,
  input  logic              i_we,
  output logic              o_ack,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [15:0]       o_ram_dat,
  input  logic [15:0]       i_ram_dat,
  output logic              o_ram_we,
  output logic [7:0]        o_io_addr,
  output logic [15:0]       o_io_dat,
  input  logic [15:0]       i_io_dat,
  output logic              o_io_re,
  output logic              o_io_we,
  input  logic              i_io_ack,
  output logic              o_buserr
);
  typedef enum logic [2:0] {IDLE, RAM_RD, RAM_WAIT, RMW_WR, IO_WAIT, DONE} state_t;
  localparam logic [7:0] WS = 8'(WAIT_STATES);
  localparam logic WS0 = WAIT_STATES == 0;
  localparam logic [7:0] TO = 8'(IO_TIMEOUT - 1);
  state_t state;
  logic [7:0] cnt, dat_b;
  logic byte_q, lane_q, we_q;
  logic req, is_io, is_byte, word_wr;
  logic [7:0] ram_lane;
  always_comb begin
    req = i_bs != 2'b00;
    is_io = i_addr[15:8] == IO_PAGE;
    is_byte = i_bs == 2'b01;
    word_wr = i_we && !is_byte;
    ram_lane = lane_q ? i_ram_dat[15:8] : i_ram_dat[7:0];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      dat_b <= '0;
      byte_q <= 1'b0;
      lane_q <= 1'b0;
      we_q <= 1'b0;
      o_dat <= '0;
      o_ack <= 1'b0;
      o_ram_addr <= '0;
      o_ram_dat <= '0;
      o_ram_we <= 1'b0;
      o_io_addr <= '0;
      o_io_dat <= '0;
      o_io_re <= 1'b0;
      o_io_we <= 1'b0;
      o_buserr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          byte_q <= is_byte;
          lane_q <= i_addr[0];
          we_q <= i_we;
          dat_b <= i_dat[7:0];
          cnt <= '0;
          if (is_io) begin
            state <= IO_WAIT;
            o_io_addr <= i_addr[7:0];
            o_io_dat <= i_dat;
            o_io_re <= !i_we;
            o_io_we <= i_we;
          end else begin
            state <= word_wr ? RMW_WR : RAM_RD;
            o_ram_addr <= i_addr[RAM_AW:1];
            o_ram_dat <= i_dat;
            o_ram_we <= word_wr && WS0;
          end
        end
        RAM_RD: state <= RAM_WAIT;
        RAM_WAIT: if (cnt != WS) cnt <= cnt + 8'd1;
        else if (we_q) begin
          state <= RMW_WR;
          cnt <= '0;
          o_ram_dat <= lane_q ? {dat_b, i_ram_dat[7:0]} : {i_ram_dat[15:8], dat_b};
          o_ram_we <= WS0;
        end else begin
          state <= DONE;
          o_ack <= 1'b1;
          o_dat <= byte_q ? {8'h00, ram_lane} : i_ram_dat;
        end
        RMW_WR: if (o_ram_we) begin
          state <= DONE;
          o_ram_we <= 1'b0;
          o_ack <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
          o_ram_we <= cnt + 8'd1 == WS;
        end
        IO_WAIT: begin
          o_io_re <= 1'b0;
          o_io_we <= 1'b0;
          if (i_io_ack) begin
            state <= DONE;
            o_ack <= 1'b1;
            o_dat <= byte_q ? {8'h00, i_io_dat[7:0]} : i_io_dat;
          end else if (cnt == TO) begin
            state <= DONE;
            o_ack <= 1'b1;
            o_buserr <= 1'b1;
            o_dat <= '0;
          end else cnt <= cnt + 8'd1;
        end
        DONE: begin
          state <= IDLE;
          o_ack <= 1'b0;
          o_buserr <= 1'b0;
          o_dat <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prim_memctl.sv
// tb_prim_memctl: directed self-checking bench for prim_memctl with zero and two wait states
module tb_prim_memctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] addr, wdat;
  logic [15:0] io_rdat = 16'h1234;
  logic [1:0] bs0, bs2;
  logic we;
  logic [15:0] dat0, dat2, ram_wdat0, ram_wdat2, ram_rdat0, ram_rdat2, io_wdat0, io_wdat2;
  logic ack0, ack2, ram_we0, ram_we2, io_re0, io_re2, io_we0, io_we2, berr0, berr2, io_ack;
  logic [13:0] ram_addr0, ram_addr2, we_addr0;
  logic [7:0] io_addr0, io_addr2;
  logic [15:0] mem0 [0:16383];
  logic [15:0] mem2 [0:16383];
  int checks = 0, errors = 0;
  int n_ack0 = 0, n_ack2 = 0, n_we0 = 0, n_we2 = 0, n_re = 0, n_iowe = 0, n_berr = 0, n_hyg = 0;
  int io_delay = -1, io_left = -1;
  int lat;
  logic [15:0] rd;
  logic be;
  int s0, s1;
  prim_memctl #(.WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat), .o_dat(dat0), .i_bs(bs0), .i_we(we),
    .o_ack(ack0), .o_ram_addr(ram_addr0), .o_ram_dat(ram_wdat0), .i_ram_dat(ram_rdat0), .o_ram_we(ram_we0),
    .o_io_addr(io_addr0), .o_io_dat(io_wdat0), .i_io_dat(io_rdat), .o_io_re(io_re0), .o_io_we(io_we0),
    .i_io_ack(io_ack), .o_buserr(berr0)
  );
  prim_memctl #(.WAIT_STATES(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat), .o_dat(dat2), .i_bs(bs2), .i_we(we),
    .o_ack(ack2), .o_ram_addr(ram_addr2), .o_ram_dat(ram_wdat2), .i_ram_dat(ram_rdat2), .o_ram_we(ram_we2),
    .o_io_addr(io_addr2), .o_io_dat(io_wdat2), .i_io_dat(io_rdat), .o_io_re(io_re2), .o_io_we(io_we2),
    .i_io_ack(io_ack), .o_buserr(berr2)
  );
  always @(posedge clk) begin
    if (ram_we0) mem0[ram_addr0] <= ram_wdat0;
    ram_rdat0 <= mem0[ram_addr0];
    if (ram_we2) mem2[ram_addr2] <= ram_wdat2;
    ram_rdat2 <= mem2[ram_addr2];
  end
  always @(posedge clk) begin
    if (io_re0 | io_we0 | io_re2 | io_we2) io_left <= io_delay < 0 ? -1 : io_delay - 1;
    else if (io_left >= 0) io_left <= io_left - 1;
  end
  assign io_ack = io_left == 0;
  always @(negedge clk) begin
    if (ack0) n_ack0++;
    if (ack2) n_ack2++;
    if (ram_we0) begin
      n_we0++;
      we_addr0 = ram_addr0;
    end
    if (ram_we2) n_we2++;
    if (io_re0) n_re++;
    if (io_we0) n_iowe++;
    if (berr0 | berr2) n_berr++;
    if (((ram_we0 | io_re0 | io_we0) & ack0) | ((ram_we2 | io_re2 | io_we2) & ack2)) n_hyg++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic access(input bit sel, input logic [15:0] a, input logic [15:0] d, input logic [1:0] b,
                        input logic w, output int l, output logic [15:0] r, output logic e);
    @(posedge clk);
    #1;
    addr = a;
    wdat = d;
    we = w;
    if (sel) bs2 = b;
    else bs0 = b;
    l = 0;
    @(negedge clk);
    while (!(sel ? ack2 : ack0) && l < 40) begin
      @(negedge clk);
      l++;
    end
    r = sel ? dat2 : dat0;
    e = sel ? berr2 : berr0;
    @(posedge clk);
    #1;
    bs0 = 2'b00;
    bs2 = 2'b00;
  endtask
  initial begin
    bs0 = 2'b00;
    bs2 = 2'b00;
    addr = '0;
    wdat = '0;
    we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, ack0}, 0);
    chk("rst_outs", {dat0, 2'b0, ram_addr0}, 0);
    chk("rst_strobes", {28'd0, ram_we0, io_re0, io_we0, berr0}, 0);
    repeat (10) @(negedge clk);
    chk("idle_activity", n_ack0 + n_ack2 + n_we0 + n_we2 + n_re + n_iowe + n_berr, 0);
    s0 = n_we0;
    access(0, 16'h0010, 16'hBEEF, 2'b11, 1'b1, lat, rd, be);
    chk("ww_lat", lat, 2);
    chk("ww_pulses", n_we0 - s0, 1);
    chk("ww_addr", we_addr0, 8);
    chk("ww_mem", mem0[8], 16'hBEEF);
    access(0, 16'h0010, 16'h0000, 2'b11, 1'b0, lat, rd, be);
    chk("wr_lat", lat, 3);
    chk("wr_dat", rd, 16'hBEEF);
    access(0, 16'h0011, 16'h005A, 2'b01, 1'b1, lat, rd, be);
    chk("bw_lat", lat, 4);
    chk("bw_mem", mem0[8], 16'h5AEF);
    access(0, 16'h0011, 16'h0000, 2'b01, 1'b0, lat, rd, be);
    chk("br_hi_lat", lat, 3);
    chk("br_hi_dat", rd, 16'h005A);
    access(0, 16'h0010, 16'h0000, 2'b01, 1'b0, lat, rd, be);
    chk("br_lo_dat", rd, 16'h00EF);
    access(0, 16'h0011, 16'h0000, 2'b10, 1'b0, lat, rd, be);
    chk("bs10_dat", rd, 16'h5AEF);
    access(0, 16'h8010, 16'h0000, 2'b11, 1'b0, lat, rd, be);
    chk("wrap_dat", rd, 16'h5AEF);
    access(1, 16'h0020, 16'h1111, 2'b11, 1'b1, lat, rd, be);
    chk("ws2_ww_lat", lat, 4);
    access(1, 16'h0020, 16'h0000, 2'b11, 1'b0, lat, rd, be);
    chk("ws2_wr_lat", lat, 5);
    chk("ws2_wr_dat", rd, 16'h1111);
    access(1, 16'h0020, 16'h00AB, 2'b01, 1'b1, lat, rd, be);
    chk("ws2_bw_lat", lat, 8);
    chk("ws2_bw_mem", mem2[16], 16'h11AB);
    io_delay = 3;
    s0 = n_re;
    access(0, 16'hFF04, 16'h0000, 2'b11, 1'b0, lat, rd, be);
    chk("io_rd_lat", lat, 5);
    chk("io_rd_dat", rd, 16'h1234);
    chk("io_rd_berr", {31'd0, be}, 0);
    chk("io_rd_addr", io_addr0, 8'h04);
    chk("io_re_pulses", n_re - s0, 1);
    io_delay = 20;
    s0 = n_iowe;
    access(0, 16'hFF08, 16'h7777, 2'b11, 1'b1, lat, rd, be);
    chk("io_to_lat", lat, 16);
    chk("io_to_berr", {31'd0, be}, 1);
    chk("io_to_dat", rd, 0);
    chk("io_we_pulses", n_iowe - s0, 1);
    chk("io_wdat", io_wdat0, 16'h7777);
    s0 = n_ack0;
    repeat (10) @(posedge clk);
    chk("late_ack_ignored", n_ack0 - s0, 0);
    io_delay = 1;
    access(0, 16'hFF05, 16'h0000, 2'b01, 1'b0, lat, rd, be);
    chk("io_br_lat", lat, 3);
    chk("io_br_dat", rd, 16'h0034);
    s0 = n_ack2;
    s1 = n_we2;
    @(posedge clk);
    #1;
    addr = 16'h0020;
    wdat = 16'h00CC;
    we = 1'b1;
    bs2 = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bs2 = 2'b00;
    repeat (12) @(posedge clk);
    chk("abort_ack", n_ack2 - s0, 0);
    chk("abort_we", n_we2 - s1, 0);
    chk("abort_mem", mem2[16], 16'h11AB);
    access(1, 16'h0020, 16'h0000, 2'b01, 1'b0, lat, rd, be);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_dat", rd, 16'h00AB);
    chk("hygiene", n_hyg, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
